// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU / DMA) in front of a single 64K x 8 memory.
// Fixed MEM_LAT-cycle access, one-cycle ack, round-robin or CPU-priority grant.
module mem_arbiter #(
  parameter int MEM_LAT  = 1,
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        owner,
  output logic        busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state_q;
  logic [3:0]  count_q;
  logic        op_q;
  logic        owner_q;
  logic        busy_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        cpu_ack_q;
  logic        dma_ack_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic [7:0]  cpu_rdata_q;
  logic [7:0]  dma_rdata_q;

  logic        win_d;
  logic        sel_we_d;
  logic [15:0] sel_addr_d;
  logic [7:0]  sel_wdata_d;

  // Winner: 1 = DMA. On a tie without priority, the non-owner gets the grant.
  always_comb begin
    win_d = owner_q;
    if (cpu_req && dma_req) begin
      win_d = CPU_PRIO ? 1'b0 : ~owner_q;
    end else if (cpu_req) begin
      win_d = 1'b0;
    end else if (dma_req) begin
      win_d = 1'b1;
    end
    sel_we_d    = win_d ? dma_we    : cpu_we;
    sel_addr_d  = win_d ? dma_addr  : cpu_addr;
    sel_wdata_d = win_d ? dma_wdata : cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      op_q        <= 1'b0;
      owner_q     <= 1'b1;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 8'd0;
      cpu_rdata_q <= 8'd0;
      dma_rdata_q <= 8'd0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner_q     <= win_d;
            op_q        <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            count_q     <= LAT_M1;
            mem_read_q  <= ~sel_we_d;
            mem_write_q <= sel_we_d;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (count_q == 4'd0) begin
            if (!op_q) begin
              if (owner_q) dma_rdata_q <= mem_rdata;
              else         cpu_rdata_q <= mem_rdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cpu_ack_q   <= ~owner_q;
            dma_ack_q   <= owner_q;
            state_q     <= ACK;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: dut_a (MEM_LAT=3, round-robin) and dut_b (MEM_LAT=1, CPU priority)
// share stimulus; each has its own memory model preloaded with addr[7:0]^addr[15:8]^0x5A (0x0010 = 0xA5).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] cpu_addr = 16'd0, dma_addr = 16'd0;
  logic [7:0]  cpu_wdata = 8'd0, dma_wdata = 8'd0;

  logic        cpu_ack_a, dma_ack_a, mem_read_a, mem_write_a, owner_a, busy_a;
  logic [7:0]  cpu_rdata_a, dma_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [15:0] mem_addr_a;
  logic        cpu_ack_b, dma_ack_b, mem_read_b, mem_write_b, owner_b, busy_b;
  logic [7:0]  cpu_rdata_b, dma_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [15:0] mem_addr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(3), .CPU_PRIO(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack_a), .cpu_rdata(cpu_rdata_a),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack_a), .dma_rdata(dma_rdata_a),
    .mem_addr(mem_addr_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .owner(owner_a), .busy(busy_a)
  );

  mem_arbiter #(.MEM_LAT(1), .CPU_PRIO(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack_b), .cpu_rdata(cpu_rdata_b),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack_b), .dma_rdata(dma_rdata_b),
    .mem_addr(mem_addr_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .owner(owner_b), .busy(busy_b)
  );

  // Memory models: filled on the first clock edge, written while the strobe is high.
  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  logic       mem_ready = 1'b0;

  function automatic logic [7:0] dflt(input int a);
    logic [15:0] w;
    w = a[15:0];
    return (w == 16'h0010) ? 8'hA5 : (w[7:0] ^ w[15:8] ^ 8'h5A);
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) begin
        mem_a[i] <= dflt(i);
        mem_b[i] <= dflt(i);
      end
      mem_ready <= 1'b1;
    end else begin
      if (mem_write_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_write_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
  end

  always @(negedge clk) begin
    mem_rdata_a <= mem_a[mem_addr_a];
    mem_rdata_b <= mem_b[mem_addr_b];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 8'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'd0; dma_wdata = 8'd0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cpu_ack_a, dma_ack_a, mem_read_a, mem_write_a, busy_a, owner_a} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b want 000001",
               {cpu_ack_a, dma_ack_a, mem_read_a, mem_write_a, busy_a, owner_a});
    end
    checks++;
    if ({mem_addr_a, mem_wdata_a, cpu_rdata_a, dma_rdata_a} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data_a: got %h want 0", {mem_addr_a, mem_wdata_a, cpu_rdata_a, dma_rdata_a});
    end
    checks++;
    if ({cpu_ack_b, dma_ack_b, mem_read_b, mem_write_b, busy_b, owner_b} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl_b: got %b want 000001",
               {cpu_ack_b, dma_ack_b, mem_read_b, mem_write_b, busy_b, owner_b});
    end
    checks++;
    if ({mem_addr_b, mem_wdata_b, cpu_rdata_b, dma_rdata_b} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data_b: got %h want 0", {mem_addr_b, mem_wdata_b, cpu_rdata_b, dma_rdata_b});
    end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    step();
    checks++;
    if ({mem_read_b, mem_write_b, busy_b, cpu_ack_b, owner_b} !== 5'b10100) begin
      errors++;
      $display("FAIL cpu_read_access: got %b want 10100", {mem_read_b, mem_write_b, busy_b, cpu_ack_b, owner_b});
    end
    checks++;
    if (mem_addr_b !== 16'h0010) begin
      errors++;
      $display("FAIL cpu_read_addr: got %h want 0010", mem_addr_b);
    end
    step();
    checks++;
    if ({cpu_ack_b, dma_ack_b, mem_read_b, busy_b, owner_b} !== 5'b10010) begin
      errors++;
      $display("FAIL cpu_read_ack: got %b want 10010", {cpu_ack_b, dma_ack_b, mem_read_b, busy_b, owner_b});
    end
    checks++;
    if ({cpu_rdata_b, dma_rdata_b} !== {8'hA5, 8'h00}) begin
      errors++;
      $display("FAIL cpu_read_data: got %h want a500", {cpu_rdata_b, dma_rdata_b});
    end
    cpu_req = 1'b0;
    step();
    checks++;
    if ({cpu_ack_b, busy_b, cpu_rdata_b} !== {2'b00, 8'hA5}) begin
      errors++;
      $display("FAIL cpu_read_hold: got %b want 0010100101", {cpu_ack_b, busy_b, cpu_rdata_b});
    end
    step();
    checks++;
    if ({cpu_ack_a, cpu_rdata_a} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL cpu_read_lat3: got %h want 1a5", {cpu_ack_a, cpu_rdata_a});
    end
    step();
  endtask

  task automatic test_dma_write();
    do_reset();
    checks++;
    if (cpu_rdata_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_clears_rdata: got %h want 00", cpu_rdata_b);
    end
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h1234; dma_wdata = 8'h3C;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if ({mem_write_a, mem_read_a, busy_a, dma_ack_a, owner_a, mem_addr_a, mem_wdata_a}
          !== {5'b10101, 16'h1234, 8'h3C}) begin
        errors++;
        $display("FAIL dma_write_cycle%0d: got %b/%h/%h want 10101/1234/3c", c,
                 {mem_write_a, mem_read_a, busy_a, dma_ack_a, owner_a}, mem_addr_a, mem_wdata_a);
      end
    end
    step();
    checks++;
    if ({dma_ack_a, cpu_ack_a, mem_write_a, busy_a, cpu_rdata_a, dma_rdata_a} !== {4'b1001, 16'h0}) begin
      errors++;
      $display("FAIL dma_write_ack: got %b/%h want 1001/0000",
               {dma_ack_a, cpu_ack_a, mem_write_a, busy_a}, {cpu_rdata_a, dma_rdata_a});
    end
    dma_req = 1'b0; dma_we = 1'b0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    step(); step(); step(); step();
    checks++;
    if ({cpu_ack_a, owner_a, cpu_rdata_a, dma_rdata_a} !== {2'b10, 8'h3C, 8'h00}) begin
      errors++;
      $display("FAIL dma_write_readback: got %b/%h want 10/3c00",
               {cpu_ack_a, owner_a}, {cpu_rdata_a, dma_rdata_a});
    end
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic exp_dma;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_addr = 16'h0041;
    for (int t = 0; t < 4; t++) begin
      exp_dma = t[0];
      step(); step(); step();
      checks++;
      if ({cpu_ack_a, dma_ack_a} !== 2'b00) begin
        errors++;
        $display("FAIL rr_early_ack%0d: got %b want 00", t, {cpu_ack_a, dma_ack_a});
      end
      step();
      checks++;
      if ({cpu_ack_a, dma_ack_a, owner_a} !== {~exp_dma, exp_dma, exp_dma}) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", t, {cpu_ack_a, dma_ack_a, owner_a},
                 {~exp_dma, exp_dma, exp_dma});
      end
      checks++;
      if ((exp_dma ? dma_rdata_a : cpu_rdata_a) !== (exp_dma ? 8'h1B : 8'h1A)) begin
        errors++;
        $display("FAIL rr_data%0d: got %h want %h", t, exp_dma ? dma_rdata_a : cpu_rdata_a,
                 exp_dma ? 8'h1B : 8'h1A);
      end
      step();
      checks++;
      if (busy_a !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: busy got %b want 0", t, busy_a);
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    step();
  endtask

  task automatic test_cpu_prio();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_addr = 16'h0041;
    for (int t = 0; t < 3; t++) begin
      step(); step();
      checks++;
      if ({cpu_ack_b, dma_ack_b, owner_b} !== 3'b100) begin
        errors++;
        $display("FAIL prio_cpu%0d: got %b want 100", t, {cpu_ack_b, dma_ack_b, owner_b});
      end
      if (t == 2) cpu_req = 1'b0;
      step();
    end
    step(); step();
    checks++;
    if ({cpu_ack_b, dma_ack_b, owner_b, dma_rdata_b} !== {3'b011, 8'h1B}) begin
      errors++;
      $display("FAIL prio_dma_after: got %b/%h want 011/1b", {cpu_ack_b, dma_ack_b, owner_b}, dma_rdata_b);
    end
    dma_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
    step(); step();
    checks++;
    if ({mem_read_a, owner_a} !== 2'b10) begin
      errors++;
      $display("FAIL mid_before: got %b want 10", {mem_read_a, owner_a});
    end
    reset = 1'b1;
    step();
    reset = 1'b0; cpu_req = 1'b0;
    checks++;
    if ({mem_read_a, busy_a, cpu_ack_a, dma_ack_a, owner_a} !== 5'b00001) begin
      errors++;
      $display("FAIL mid_abort: got %b want 00001", {mem_read_a, busy_a, cpu_ack_a, dma_ack_a, owner_a});
    end
    step(); step();
    checks++;
    if ({cpu_ack_a, busy_a, mem_read_a} !== 3'b000) begin
      errors++;
      $display("FAIL mid_no_ack: got %b want 000", {cpu_ack_a, busy_a, mem_read_a});
    end
    cpu_req = 1'b1;
    step(); step(); step(); step();
    checks++;
    if ({cpu_ack_a, cpu_rdata_a} !== {1'b1, 8'h0A}) begin
      errors++;
      $display("FAIL mid_fresh: got %h want 10a", {cpu_ack_a, cpu_rdata_a});
    end
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_addr_change();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    step();
    cpu_addr = 16'h0030;
    step();
    checks++;
    if (mem_addr_a !== 16'h0020) begin
      errors++;
      $display("FAIL addr_hold: got %h want 0020", mem_addr_a);
    end
    step(); step();
    checks++;
    if ({cpu_ack_a, cpu_rdata_a} !== {1'b1, 8'h7A}) begin
      errors++;
      $display("FAIL addr_data: got %h want 17a", {cpu_ack_a, cpu_rdata_a});
    end
    cpu_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_round_robin();
    test_cpu_prio();
    test_reset_mid();
    test_addr_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 64K x 8 memory between two requesters: the CPU control unit and a DMA/loader port (program load, debug peek/poke).
- Sits between both requesters and the memory block. Owns the memory's addr, READ, WRITE and data_in. Returns read data and a one-cycle acknowledge to whichever requester was granted.
- Arbitration is round-robin, or fixed CPU priority when configured. Each access takes a fixed, parameterised number of memory cycles.

Parameters:
MEM_LAT, 1, memory access cycles per transaction (legal 1..15); READ or WRITE strobe held this many cycles
CPU_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = CPU always wins ties

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU request; held until cpu_ack sampled high
cpu_we  input  1  1 = write, 0 = read; valid with cpu_req
cpu_addr  input  16  CPU address
cpu_wdata  input  8  CPU write data
cpu_ack  output  1  one-cycle completion pulse to CPU
cpu_rdata  output  8  read data, valid when cpu_ack = 1 and held until next CPU read completes
dma_req  input  1  DMA request; same rules as cpu_req
dma_we  input  1  DMA write enable
dma_addr  input  16  DMA address
dma_wdata  input  8  DMA write data
dma_ack  output  1  one-cycle completion pulse to DMA
dma_rdata  output  8  DMA read data; same holding rule as cpu_rdata
mem_addr  output  16  memory address (latched request address)
mem_read  output  1  memory READ strobe
mem_write  output  1  memory WRITE strobe
mem_wdata  output  8  memory write data (latched)
mem_rdata  input  8  memory read data (combinational from memory)
owner  output  1  0 = CPU, 1 = DMA; requester of current or last transaction
busy  output  1  1 in ACCESS and ACK states

Behaviour:
- Reset values (applied at the posedge where reset = 1):
  - state = IDLE; mem_read = mem_write = 0; cpu_ack = dma_ack = 0.
  - cpu_rdata = dma_rdata = 0; mem_addr = 0; mem_wdata = 0.
  - owner = 1 (DMA), so the CPU wins the first round-robin tie; count = 0.
- Reset mid-transaction: the access is aborted, no ack is issued, and strobes read 0 from the cycle after the reset edge.
- Outputs are all registered.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - On a request, select the winner, latch its we/addr/wdata into mem_addr/mem_wdata/op, and set owner = winner.
    - Set count = MEM_LAT-1 and go to ACCESS.
  - ACCESS:
    - mem_read = ~op or mem_write = op, asserted for exactly MEM_LAT consecutive cycles.
    - When count = 0: on a read, capture mem_rdata into the winner's rdata at that edge; clear strobes; go to ACK.
    - Otherwise decrement count.
  - ACK:
    - Winner's ack = 1 for exactly one cycle; go to IDLE.
    - Requests are ignored in this state.
- Arbitration in IDLE:
  - Only one request: that requester wins.
  - Both requests, CPU_PRIO = 1: CPU wins.
  - Both requests, CPU_PRIO = 0: the requester that is not the current owner wins.
- Handshake:
  - Requester holds req, we, addr and wdata stable until it samples ack = 1.
  - It drops req on that same edge, or keeps it high to issue a new request, which is evaluated in the following IDLE cycle.
  - Request inputs are only sampled in IDLE; changes during ACCESS or ACK have no effect.
- Latency: req high in cycle 0 (IDLE) -> ACCESS in cycles 1..MEM_LAT -> ack in cycle MEM_LAT+1.
- Throughput: one transaction per MEM_LAT+2 cycles; back-to-back requests return to IDLE for one cycle between transactions.
- Non-winner rdata is unchanged; a write never changes either rdata.
- mem_addr and mem_wdata hold their last latched values while in IDLE; strobes are 0 in IDLE and ACK.
- Counter is 4 bits; MEM_LAT values outside 1..15 are illegal (elaboration-time check).

Test Plan:
1. Reset then single CPU read (MEM_LAT=1, mem[0x0010]=0xA5): cpu_req, cpu_addr=0x0010 at cycle 0 -> mem_read=1 with mem_addr=0x0010 in cycle 1 only; cpu_ack=1, cpu_rdata=0xA5 in cycle 2; owner=0.
2. DMA write (MEM_LAT=3): dma_we=1, dma_addr=0x1234, dma_wdata=0x3C -> mem_write=1 in cycles 1-3, mem_wdata=0x3C; dma_ack in cycle 4; a subsequent CPU read of 0x1234 returns 0x3C.
3. Simultaneous requests held, CPU_PRIO=0, from reset -> grants alternate CPU, DMA, CPU, DMA; acks spaced MEM_LAT+2 cycles; neither requester is starved.
4. Same stimulus with CPU_PRIO=1 and cpu_req held continuously -> every grant goes to CPU; dma_ack never asserts until cpu_req drops, then DMA is served next.
5. Reset asserted during ACCESS cycle 2 of 3 -> mem_read=0 from the next cycle, no ack, state IDLE, owner=1; a fresh request completes normally.
6. CPU changes cpu_addr from 0x0020 to 0x0030 during ACCESS -> mem_addr stays 0x0020; returned data is mem[0x0020].
